// File: rtl/cnu_pkg.sv
// Shared types and helpers for the min-sum check-node sequencer.
package cnu_pkg;

    typedef enum logic [1:0] {
        StCollect = 2'd0,
        StEval    = 2'd1,
        StCapt    = 2'd2
    } state_t;

    localparam int unsigned DATA_W = 7;
    localparam int unsigned IDX_W  = 8;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

    function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/cnu_msg_buf.sv
// D-slot magnitude/sign buffer filled serially by a write pointer, with running sign parity.
module cnu_msg_buf
    import cnu_pkg::*;
#(
    parameter int unsigned data_w = DATA_W,
    parameter int unsigned D      = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_wr,
    input  logic [data_w:0]      i_data,
    output logic [data_w*D-1:0]  o_mags,
    output logic [D-1:0]         o_signs,
    output logic                 o_parity,
    output logic                 o_last
);

    localparam int unsigned CNT_W = clog2(D);

    logic [CNT_W-1:0]    r_cnt;
    logic [data_w*D-1:0] r_mags;
    logic [D-1:0]        r_signs;
    logic                r_par;
    logic                w_sgn;
    logic [data_w-1:0]   w_mag;

    assign w_sgn    = i_data[data_w];
    assign w_mag    = i_data[data_w-1:0];
    assign o_last   = (r_cnt == CNT_W'(D - 1));
    assign o_mags   = r_mags;
    assign o_signs  = r_signs;
    assign o_parity = r_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_mags  <= '0;
            r_signs <= '0;
            r_par   <= 1'b0;
        end else if (i_wr) begin
            r_mags[r_cnt*data_w +: data_w] <= w_mag;
            r_signs[r_cnt]                 <= w_sgn;
            // Slot 0 restarts the parity so no clear cycle is needed between rows.
            r_par                          <= (r_cnt == '0) ? w_sgn : (r_par ^ w_sgn);
            r_cnt                          <= o_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cnu_min_sched.sv
// Check-node sequencer: collects one row, fires the external min tree, emits a compressed message.
module cnu_min_sched
    import cnu_pkg::*;
#(
    parameter int unsigned data_w = DATA_W,
    parameter int unsigned idx_w  = IDX_W,
    parameter int unsigned D      = 5,
    parameter int unsigned OFFSET = 1,
    parameter int unsigned ROWS   = 4,
    localparam int unsigned row_w = (clog2(ROWS) < 1) ? 1 : clog2(ROWS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [data_w:0]      in_data,
    output logic                 tree_en,
    output logic [data_w*D-1:0]  tree_in,
    input  logic [data_w-1:0]    tree_min,
    input  logic [data_w-1:0]    tree_min2,
    input  logic [idx_w-1:0]     tree_min_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [data_w-1:0]    out_min,
    output logic [data_w-1:0]    out_min2,
    output logic [idx_w-1:0]     out_idx,
    output logic                 out_sgn,
    output logic [D-1:0]         out_signs,
    output logic [row_w-1:0]     out_row,
    output logic                 out_last
);

    state_t            r_state, w_state_d;
    logic [row_w-1:0]  r_row;
    logic              w_accept, w_capture, w_buf_last, w_parity;
    logic [D-1:0]      w_signs;
    logic [idx_w-1:0]  w_idx;

    assign in_ready  = rst_n && (r_state == StCollect);
    assign tree_en   = (r_state == StEval);
    assign w_accept  = in_valid && in_ready;
    assign w_capture = (r_state == StCapt) && (!out_valid || out_ready);
    // A padding slot can only win when every magnitude is all-ones; any real slot ties it.
    assign w_idx     = (tree_min_idx >= idx_w'(D)) ? idx_w'(D - 1) : tree_min_idx;

    cnu_msg_buf #(
        .data_w (data_w),
        .D      (D)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_wr     (w_accept),
        .i_data   (in_data),
        .o_mags   (tree_in),
        .o_signs  (w_signs),
        .o_parity (w_parity),
        .o_last   (w_buf_last)
    );

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StCollect: if (w_accept && w_buf_last) w_state_d = StEval;
            StEval:    w_state_d = StCapt;
            StCapt:    if (w_capture) w_state_d = StCollect;
            default:   w_state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StCollect;
            r_row     <= '0;
            out_valid <= 1'b0;
            out_min   <= '0;
            out_min2  <= '0;
            out_idx   <= '0;
            out_sgn   <= 1'b0;
            out_signs <= '0;
            out_row   <= '0;
            out_last  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_capture) begin
                out_valid <= 1'b1;
                out_min   <= data_w'(sat_sub(32'(tree_min), OFFSET));
                out_min2  <= data_w'(sat_sub(32'(tree_min2), OFFSET));
                out_idx   <= w_idx;
                out_sgn   <= w_parity;
                out_signs <= w_signs;
                out_row   <= r_row;
                out_last  <= (r_row == row_w'(ROWS - 1));
                r_row     <= (r_row == row_w'(ROWS - 1)) ? '0 : r_row + 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cnu_min_sched.sv
// Scoreboard bench for cnu_min_sched with a registered behavioural min tree attached.
module tb_cnu_min_sched;

    localparam int DW = 7;
    localparam int IW = 8;
    localparam int D  = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW:0]     in_data = '0;
    logic            tree_en;
    logic [DW*D-1:0] tree_in;
    logic [DW-1:0]   tree_min, tree_min2;
    logic [IW-1:0]   tree_min_idx;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [DW-1:0]   out_min, out_min2;
    logic [IW-1:0]   out_idx;
    logic            out_sgn;
    logic [D-1:0]    out_signs;
    logic [1:0]      out_row;
    logic            out_last;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [DW-1:0] mn;
        logic [DW-1:0] mn2;
        logic [IW-1:0] idx;
        logic          sgn;
        logic [D-1:0]  signs;
        logic [1:0]    row;
        logic          last;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    cnu_min_sched #(
        .data_w (DW),
        .idx_w  (IW),
        .D      (D),
        .OFFSET (1),
        .ROWS   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .tree_en      (tree_en),
        .tree_in      (tree_in),
        .tree_min     (tree_min),
        .tree_min2    (tree_min2),
        .tree_min_idx (tree_min_idx),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_min      (out_min),
        .out_min2     (out_min2),
        .out_idx      (out_idx),
        .out_sgn      (out_sgn),
        .out_signs    (out_signs),
        .out_row      (out_row),
        .out_last     (out_last)
    );

    // Tree pads odd D with an all-ones slot; ties go to the later slot.
    logic [DW*(D+1)-1:0] padded;
    logic [DW-1:0]       c_m1, c_m2, c_v;
    logic [IW-1:0]       c_ix;
    assign padded = {7'h7f, tree_in};

    always_comb begin
        c_m1 = '1;
        c_m2 = '1;
        c_ix = '0;
        c_v  = '0;
        for (int k = 0; k < D + 1; k++) begin
            c_v = padded[k*DW +: DW];
            if (c_v <= c_m1) begin
                c_m2 = c_m1;
                c_m1 = c_v;
                c_ix = IW'(k);
            end else if (c_v < c_m2) begin
                c_m2 = c_v;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tree_min     <= '0;
            tree_min2    <= '0;
            tree_min_idx <= '0;
        end else if (tree_en) begin
            tree_min     <= c_m1;
            tree_min2    <= c_m2;
            tree_min_idx <= c_ix;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [DW-1:0] mn, input logic [DW-1:0] mn2, input logic [IW-1:0] idx,
                        input logic sgn, input logic [D-1:0] signs, input logic [1:0] row,
                        input logic last);
        exp_t e;
        e = '{mn: mn, mn2: mn2, idx: idx, sgn: sgn, signs: signs, row: row, last: last};
        exp_q.push_back(e);
    endtask

    task automatic send_msg(input logic s, input logic [DW-1:0] m);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = {s, m};
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: in_ready stuck 0, required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Slot k magnitude at mags[k*DW +: DW], sign at sg[k].
    task automatic send_row(input logic [DW*D-1:0] mags, input logic [D-1:0] sg);
        for (int k = 0; k < D; k++) begin
            send_msg(sg[k], mags[k*DW +: DW]);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got min %0d, required no output", out_min);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_min",   32'(out_min),   32'(e.mn));
                    chk("out_min2",  32'(out_min2),  32'(e.mn2));
                    chk("out_idx",   32'(out_idx),   32'(e.idx));
                    chk("out_sgn",   32'(out_sgn),   32'(e.sgn));
                    chk("out_signs", 32'(out_signs), 32'(e.signs));
                    chk("out_row",   32'(out_row),   32'(e.row));
                    chk("out_last",  32'(out_last),  32'(e.last));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_tree_en",   32'(tree_en),   32'd0);
        chk("rst_out_min",   32'(out_min),   32'd0);
        chk("rst_out_signs", 32'(out_signs), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Basic row: 9,4,12,3,7 signs 1,0,0,1,1
        push(7'd2, 7'd3, 8'd3, 1'b1, 5'b11001, 2'd0, 1'b0);
        send_row({7'd7, 7'd3, 7'd12, 7'd4, 7'd9}, 5'b11001);
        @(negedge clk);
        chk("lat_tree_en", 32'(tree_en), 32'd1);
        chk("lat_eval_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_capt_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        drain();

        // Saturation: 0,1,5,6,2
        push(7'd0, 7'd0, 8'd0, 1'b0, 5'b00000, 2'd1, 1'b0);
        send_row({7'd2, 7'd6, 7'd5, 7'd1, 7'd0}, 5'b00000);
        drain();

        // Backpressure: two rows with the consumer stalled
        out_ready = 1'b0;
        push(7'd9, 7'd19, 8'd0, 1'b1, 5'b00010, 2'd2, 1'b0);
        send_row({7'd50, 7'd40, 7'd30, 7'd20, 7'd10}, 5'b00010);
        push(7'd4, 7'd5, 8'd3, 1'b1, 5'b11111, 2'd3, 1'b1);
        send_row({7'd30, 7'd5, 7'd7, 7'd6, 7'd8}, 5'b11111);
        repeat (4) @(negedge clk);
        chk("bp_in_ready",  32'(in_ready),  32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_min",  32'(out_min),   32'd9);
        chk("bp_hold_row",  32'(out_row),   32'd2);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_swap_valid", 32'(out_valid), 32'd1);
        chk("bp_swap_min",   32'(out_min),   32'd4);
        chk("bp_swap_last",  32'(out_last),  32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Row wrap: slots i+3,i+2,i+5,i+4,i+6, sign only on slot i
        for (int i = 0; i < 5; i++) begin
            push(7'(i + 1), 7'(i + 2), 8'd1, 1'b1, 5'(1 << i), 2'(i % 4), (i == 3));
            send_row({7'(i + 6), 7'(i + 4), 7'(i + 5), 7'(i + 2), 7'(i + 3)}, 5'(1 << i));
        end
        drain();

        // All-max odd D: padding slot wins, index clamps to D-1
        push(7'd126, 7'd126, 8'd4, 1'b0, 5'b00000, 2'd1, 1'b0);
        send_row({7'd127, 7'd127, 7'd127, 7'd127, 7'd127}, 5'b00000);
        drain();

        // Reset mid-row
        send_msg(1'b1, 7'd0);
        send_msg(1'b1, 7'd0);
        send_msg(1'b1, 7'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_min2",  32'(out_min2),  32'd0);
        chk("midrst_out_row",   32'(out_row),   32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        push(7'd0, 7'd1, 8'd0, 1'b0, 5'b00000, 2'd0, 1'b0);
        send_row({7'd5, 7'd4, 7'd3, 7'd2, 7'd1}, 5'b00000);
        drain();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
